inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Fetch-side writer for the dual-issue instruction FIFO.
- Generates sequential and redirected PCs and drives an SRAM-like request/response interface to the I-cache, one request outstanding at a time.
- Pushes returned instruction pairs into the FIFO write port (write_en1/2, data, address, exception).
- Discards responses that belong to requests made obsolete by a branch or exception redirect.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- EXP_W, 12, width of the per-fetch exception field: {exl_set, asid[7:0], inst_miss, inst_illegal, tlb_invalid}.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch taken / flush; same cycle as FIFO rst
- redirect_pc  in  32  new fetch target
- fifo_full  in  1  FIFO has fewer than 2 free slots
- inst_req  out  1  request valid
- inst_addr  out  32  request address, word aligned
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response valid this cycle
- inst_rdata1  in  32  word at inst_addr
- inst_rdata2  in  32  word at inst_addr+4
- inst_exp_in  in  EXP_W  MMU/TLB exception bits for the response
- write_en1  out  1  FIFO push, first word
- write_en2  out  1  FIFO push, second word
- write_data1  out  32  first word
- write_data2  out  32  second word
- write_address1  out  32  first word PC
- write_address2  out  32  second word PC
- write_inst_exp1  out  EXP_W  exception bits, applied to both words
- fetch_pc  out  32  next PC to fetch (debug)

Behaviour:
- State registers: pc, req_addr, drop_pending, state ∈ {IDLE, REQ, WAIT, DROP}.
- Reset values: state=IDLE, pc=RESET_PC, req_addr=0, drop_pending=0.
- Outputs during reset: inst_req=0, write_en1/2=0, all write_* data=0.
- Redirect priority: redirect_valid loads pc<=redirect_pc in every state. It overrides the sequential increment in the same cycle.
- can_issue = redirect_valid | ~fifo_full. Fullness is ignored on redirect because the FIFO is being reset.
- IDLE:
  - If can_issue: go to REQ with req_addr = redirect_valid ? redirect_pc : pc.
  - Otherwise stay in IDLE.
- REQ:
  - inst_req=1, inst_addr=req_addr. Both are held stable until inst_addr_ok.
  - On inst_addr_ok: go to DROP if (drop_pending | redirect_valid), else go to WAIT. Clear drop_pending.
  - redirect_valid without inst_addr_ok: set drop_pending, stay in REQ with the same address.
- WAIT:
  - On inst_data_ok: write_en1=1 in the same cycle (combinational, zero latency).
  - write_en2 = ~req_addr[2], so a pair is only pushed from an 8-byte-aligned address.
  - write_data1/2 = rdata1/2, write_address1 = req_addr, write_address2 = req_addr+4, write_inst_exp1 = inst_exp_in.
  - pc <= req_addr + (req_addr[2] ? 4 : 8), unless redirect_valid.
  - Next state is REQ (with the next PC) if can_issue, else IDLE.
  - A response in the same cycle as redirect_valid is still written: it is the delay-slot candidate captured by the FIFO.
  - redirect_valid without inst_data_ok: go to DROP.
- DROP:
  - On inst_data_ok: no write_en. Go to REQ with req_addr=pc if can_issue, else IDLE.
  - redirect_valid in DROP only updates pc.
- PC arithmetic is 32-bit with natural wrap at 2^32.
- write_en2=1 is never asserted without write_en1=1.
- Asserting resetn mid-transaction returns to IDLE immediately. Any response still owed by the cache is the cache's responsibility to squash on reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds 32-bit outputs perf_req_cnt, perf_drop_cnt and perf_full_stall_cnt. These are reset to 0 and count, respectively:
  - accepted requests,
  - discarded responses,
  - cycles spent in IDLE with fifo_full=1 and redirect_valid=0.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: fetch_state_t enum (IDLE, REQ, WAIT, DROP), EXP_W, RESET_PC default, and the exception-field bit-index constants.
- One sub-module is natural: fetch_pc_next, which is combinational. It takes pc, req_addr, redirect and state, and produces the next pc and next req_addr.

Test Plan:
- Reset release, fifo_full=0, cache grants immediately with data_ok one cycle later:
  - first inst_addr=BFC0_0000, push pair with write_address1/2 = BFC0_0000/BFC0_0004;
  - next inst_addr=BFC0_0008.
- redirect_pc=8000_0104 with no other traffic:
  - single push write_en1=1, write_en2=0;
  - next inst_addr=8000_0108, then pairs from 8000_0110.
- redirect_valid in WAIT one cycle before data_ok:
  - that response is not written (drop);
  - next inst_addr equals redirect_pc.
- redirect_valid in the same cycle as data_ok:
  - pair is written in that cycle;
  - next inst_addr equals redirect_pc.
- redirect_valid in REQ while inst_addr_ok=0 for 3 cycles:
  - inst_addr held at the old value;
  - after accept, the response is dropped, then redirect_pc is requested.
- fifo_full=1 after a push:
  - inst_req stays 0 in IDLE;
  - on deassertion, request at pc+8 within 1 cycle;
  - with FETCH_PERF_CNT_EN, perf_full_stall_cnt equals the stall length.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Defines the fetch FSM states, the exception-field width and bit positions,
// and the default reset PC.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Exception field layout: {exl_set, asid[7:0], inst_miss, inst_illegal, tlb_invalid}
  localparam int FETCH_EXP_W      = 12;
  localparam int EXP_TLB_INVALID  = 0;
  localparam int EXP_INST_ILLEGAL = 1;
  localparam int EXP_INST_MISS    = 2;
  localparam int EXP_ASID_LSB     = 3;
  localparam int EXP_ASID_MSB     = 10;
  localparam int EXP_EXL_SET      = 11;

  // Advance past the words just fetched: a pair from an 8-byte-aligned
  // address, a single word otherwise.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] addr);
    return addr + (addr[2] ? 32'd4 : 32'd8);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_pc_next.sv
// Next-PC logic (fetch_pc_next) for the instruction fetch controller.
// Purely combinational: computes the next pc and the next request address
// from the current state, redirect and cache handshake.
module inst_fetch_ctrl_pc_next
  import inst_fetch_ctrl_pkg::*;
(
  input  fetch_state_t state,
  input  logic [31:0]  pc,
  input  logic [31:0]  req_addr,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         data_ok,
  input  logic         can_issue,
  output logic [31:0]  pc_nxt,
  output logic [31:0]  req_addr_nxt
);

  // Redirect always wins; a response in WAIT advances sequentially; a new
  // request (entering REQ) always targets the freshly computed pc.
  always_comb begin
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
    end else if (state == WAIT && data_ok) begin
      pc_nxt = seq_next_pc(req_addr);
    end
    case (state)
      IDLE:      if (can_issue) req_addr_nxt = pc_nxt;
      WAIT, DROP: if (data_ok && can_issue) req_addr_nxt = pc_nxt;
      default:   req_addr_nxt = req_addr;
    endcase
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one I-cache request at a time,
// pushes returned instruction pairs into the dual-issue FIFO and discards
// responses made stale by a redirect.
// Optional macro FETCH_PERF_CNT_EN adds request/drop/full-stall counters.
//
// Handshake: inst_req/inst_addr are held stable from the cycle the FSM
// enters REQ until the cycle inst_addr_ok is seen high; inst_data_ok is a
// single-cycle response pulse for the one outstanding request.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          EXP_W    = FETCH_EXP_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             fifo_full,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata1,
  input  logic [31:0]      inst_rdata2,
  input  logic [EXP_W-1:0] inst_exp_in,
  output logic             write_en1,
  output logic             write_en2,
  output logic [31:0]      write_data1,
  output logic [31:0]      write_data2,
  output logic [31:0]      write_address1,
  output logic [31:0]      write_address2,
  output logic [EXP_W-1:0] write_inst_exp1,
  output logic [31:0]      fetch_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      perf_req_cnt,
  output logic [31:0]      perf_drop_cnt,
  output logic [31:0]      perf_full_stall_cnt,
`endif
  output logic [1:0]       state_dbg
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         drop_pending;
  logic [31:0]  pc_nxt;
  logic [31:0]  req_addr_nxt;
  logic         can_issue;
  logic         resp_write;

  // A redirect resets the FIFO, so its fullness no longer matters.
  assign can_issue = redirect_valid | ~fifo_full;

  inst_fetch_ctrl_pc_next u_fetch_pc_next (
    .state          (state),
    .pc             (pc),
    .req_addr       (req_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .data_ok        (inst_data_ok),
    .can_issue      (can_issue),
    .pc_nxt         (pc_nxt),
    .req_addr_nxt   (req_addr_nxt)
  );

  // Fetch FSM with pc, request address and stale-response tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= 32'd0;
      drop_pending <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      case (state)
        IDLE: if (can_issue) state <= REQ;
        REQ: begin
          if (inst_addr_ok) begin
            state        <= (drop_pending | redirect_valid) ? DROP : WAIT;
            drop_pending <= 1'b0;
          end else if (redirect_valid) begin
            drop_pending <= 1'b1;
          end
        end
        WAIT: begin
          if (inst_data_ok) state <= can_issue ? REQ : IDLE;
          else if (redirect_valid) state <= DROP;
        end
        DROP: if (inst_data_ok) state <= can_issue ? REQ : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A live response is pushed in the cycle it arrives, even alongside a
  // redirect (it is the delay-slot candidate).
  assign resp_write      = (state == WAIT) & inst_data_ok;
  assign write_en1       = resp_write;
  assign write_en2       = resp_write & ~req_addr[2];
  assign write_data1     = resp_write ? inst_rdata1 : 32'd0;
  assign write_data2     = resp_write ? inst_rdata2 : 32'd0;
  assign write_address1  = resp_write ? req_addr : 32'd0;
  assign write_address2  = resp_write ? req_addr + 32'd4 : 32'd0;
  assign write_inst_exp1 = resp_write ? inst_exp_in : '0;

  assign inst_req  = (state == REQ);
  assign inst_addr = req_addr;
  assign fetch_pc  = pc;
  assign state_dbg = state;

`ifdef FETCH_PERF_CNT_EN
  // Event counters: accepted requests, discarded responses, full stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_req_cnt        <= 32'd0;
      perf_drop_cnt       <= 32'd0;
      perf_full_stall_cnt <= 32'd0;
    end else begin
      if (state == REQ && inst_addr_ok) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (state == DROP && inst_data_ok) perf_drop_cnt <= perf_drop_cnt + 32'd1;
      if (state == IDLE && fifo_full && !redirect_valid)
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: cache responses are driven from
// tasks, expected FIFO pushes are queued when a response is driven and
// compared when the DUT raises write_en1.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam int EW = FETCH_EXP_W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          fifo_full = 1'b0;
  logic          inst_req;
  logic [31:0]   inst_addr;
  logic          inst_addr_ok = 1'b0;
  logic          inst_data_ok = 1'b0;
  logic [31:0]   inst_rdata1 = 32'd0;
  logic [31:0]   inst_rdata2 = 32'd0;
  logic [EW-1:0] inst_exp_in = '0;
  logic          write_en1, write_en2;
  logic [31:0]   write_data1, write_data2, write_address1, write_address2;
  logic [EW-1:0] write_inst_exp1;
  logic [31:0]   fetch_pc;
  logic [1:0]    state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_req_cnt, perf_drop_cnt, perf_full_stall_cnt;
  logic [31:0]   stall_base;
`endif

  inst_fetch_ctrl dut (
    .clk             (clk),
    .resetn          (resetn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fifo_full       (fifo_full),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata1     (inst_rdata1),
    .inst_rdata2     (inst_rdata2),
    .inst_exp_in     (inst_exp_in),
    .write_en1       (write_en1),
    .write_en2       (write_en2),
    .write_data1     (write_data1),
    .write_data2     (write_data2),
    .write_address1  (write_address1),
    .write_address2  (write_address2),
    .write_inst_exp1 (write_inst_exp1),
    .fetch_pc        (fetch_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_req_cnt        (perf_req_cnt),
    .perf_drop_cnt       (perf_drop_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt),
`endif
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          en2;
    logic [31:0]   a1;
    logic [31:0]   a2;
    logic [31:0]   d1;
    logic [31:0]   d2;
    logic [EW-1:0] ex;
  } wr_t;
  localparam int WR_W = $bits(wr_t);
  logic [WR_W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Every push is compared against the oldest expected record.
  always @(negedge clk) begin
    if (resetn && write_en1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h required=no_write @%0t", write_address1, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_en2", write_en2, w.en2);
        chk("wr_addr1", write_address1, w.a1);
        chk("wr_addr2", write_address2, w.a2);
        chk("wr_data1", write_data1, w.d1);
        chk("wr_data2", write_data2, w.d2);
        chk("wr_exp", write_inst_exp1, w.ex);
      end
    end
    if (write_en2 && !write_en1) begin
      checks++;
      failures++;
      $display("FAIL en2_without_en1 actual=1 required=0 @%0t", $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (!inst_req && n < bound) begin
      cyc();
      n++;
    end
    chk("req_within_bound", inst_req, 1'b1);
  endtask

  task automatic grant();
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
  endtask

  // Drive one response that must be pushed; expected record queued first.
  task automatic resp_write(input logic [31:0] addr, input logic en2, input logic full_after);
    wr_t w;
    w.en2 = en2;
    w.a1  = addr;
    w.a2  = addr + 32'd4;
    w.d1  = $urandom;
    w.d2  = $urandom;
    w.ex  = EW'($urandom_range(0, 4095));
    exp_q.push_back(w);
    inst_rdata1  = w.d1;
    inst_rdata2  = w.d2;
    inst_exp_in  = w.ex;
    inst_data_ok = 1'b1;
    fifo_full    = full_after;
    cyc();
    inst_data_ok = 1'b0;
  endtask

  // Drive a response that must be discarded.
  task automatic resp_drop();
    inst_rdata1  = $urandom;
    inst_rdata2  = $urandom;
    inst_data_ok = 1'b1;
    @(negedge clk);
    chk("drop_no_write", write_en1, 1'b0);
    @(posedge clk);
    #1;
    inst_data_ok = 1'b0;
  endtask

  task automatic issue_fetch(input logic [31:0] addr, input logic en2, input logic full_after);
    wait_req(4);
    chk("req_addr", inst_addr, addr);
    grant();
    resp_write(addr, en2, full_after);
  endtask

  // ---------------- redirect vector table ----------------
  typedef struct {
    logic [31:0] target;
    logic        en2_first;
    logic [31:0] second;
    logic        en2_second;
  } redir_vec_t;
  redir_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h8000_0104, 1'b0, 32'h8000_0108, 1'b1};
    vecs[1] = '{32'h8000_0100, 1'b1, 32'h8000_0108, 1'b1};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFF8, 1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0010, 1'b1, 32'h0000_0018, 1'b1};

    // reset state
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_inst_req", inst_req, 1'b0);
    chk("rst_we1", write_en1, 1'b0);
    chk("rst_we2", write_en2, 1'b0);
    chk("rst_wdata1", write_data1, 32'd0);
    chk("rst_waddr1", write_address1, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'hBFC0_0000);
    chk("rst_state", state_dbg, 2'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // sequential fetch from reset PC
    issue_fetch(32'hBFC0_0000, 1'b1, 1'b0);
    issue_fetch(32'hBFC0_0008, 1'b1, 1'b1);

    // fifo_full stall in IDLE
`ifdef FETCH_PERF_CNT_EN
    stall_base = perf_full_stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_req", inst_req, 1'b0);
      cyc();
    end
    fifo_full = 1'b0;
    wait_req(1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_full_stall_cnt - stall_base, 32'd5);
`endif
    issue_fetch(32'hBFC0_0010, 1'b1, 1'b1);

    // table: redirect from IDLE, then the following sequential fetch
    for (int i = 0; i < 5; i++) begin
      chk("idle_no_req", inst_req, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      cyc();
      redirect_valid = 1'b0;
      fifo_full      = 1'b0;
      chk("redir_fetch_pc", fetch_pc, vecs[i].target);
      issue_fetch(vecs[i].target, vecs[i].en2_first, 1'b0);
      issue_fetch(vecs[i].second, vecs[i].en2_second, 1'b1);
    end
    fifo_full = 1'b0;
    issue_fetch(32'h0000_0020, 1'b1, 1'b0);

    // redirect in WAIT one cycle before the response: response dropped
    wait_req(4);
    chk("t3_addr", inst_addr, 32'h0000_0028);
    grant();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_5670;
    cyc();
    redirect_valid = 1'b0;
    resp_drop();
    issue_fetch(32'h1234_5670, 1'b1, 1'b0);

    // redirect in the same cycle as the response: response still written
    wait_req(4);
    chk("t4_addr", inst_addr, 32'h1234_5678);
    grant();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hA000_0004;
    resp_write(32'h1234_5678, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    issue_fetch(32'hA000_0004, 1'b0, 1'b0);

    // redirect in REQ while the cache withholds addr_ok for 3 cycles
    wait_req(4);
    for (int i = 0; i < 3; i++) begin
      chk("t5_addr_hold", inst_addr, 32'hA000_0008);
      chk("t5_req_hold", inst_req, 1'b1);
      redirect_valid = (i == 0);
      redirect_pc    = 32'h0040_0000;
      cyc();
    end
    redirect_valid = 1'b0;
    chk("t5_addr_after", inst_addr, 32'hA000_0008);
    grant();
    resp_drop();
    issue_fetch(32'h0040_0000, 1'b1, 1'b1);
    chk("final_idle", inst_req, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_drop", perf_drop_cnt, 32'd2);
`endif

    cyc();
    cyc();
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
